// File: rtl/ten_bit_program_counter.sv
// 10-bit program counter with jump, call/return through a small LIFO return-address stack.
// One operation per cycle by priority ret > call > load > inc; all outputs registered.
module ten_bit_program_counter #(
  parameter int STACK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [9:0] load_addr,
  input  logic       call,
  input  logic       ret,
  output logic [9:0] pc,
  output logic       o,
  output logic       stack_full,
  output logic       stack_empty,
  output logic       stack_err
);

  localparam int OCC_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [9:0]       pc_q, pc_d;
  logic             o_q, o_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             err_q, err_d;
  logic [9:0]       stack_q [STACK_DEPTH];

  logic             push_en;
  logic             full, empty;
  logic [OCC_W-1:0] occ_m1;
  logic [IDX_W-1:0] push_idx, pop_idx;
  logic [9:0]       pc_inc;

  assign full     = (occ_q == OCC_W'(STACK_DEPTH));
  assign empty    = (occ_q == '0);
  assign occ_m1   = occ_q - OCC_W'(1);
  assign push_idx = occ_q[IDX_W-1:0];
  assign pop_idx  = occ_m1[IDX_W-1:0];
  assign pc_inc   = pc_q + 10'd1;

  always_comb begin
    pc_d    = pc_q;
    o_d     = 1'b0;
    occ_d   = occ_q;
    err_d   = err_q;
    push_en = 1'b0;
    if (ret) begin
      if (empty) begin
        err_d = 1'b1;
      end else begin
        pc_d  = stack_q[pop_idx];
        occ_d = occ_m1;
      end
    end else if (call) begin
      if (full) begin
        err_d = 1'b1;
      end else begin
        push_en = 1'b1;
        occ_d   = occ_q + OCC_W'(1);
        pc_d    = load_addr;
      end
    end else if (load) begin
      pc_d = load_addr;
    end else if (inc) begin
      pc_d = pc_inc;
      o_d  = &pc_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= '0;
      o_q   <= 1'b0;
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      o_q   <= o_d;
      occ_q <= occ_d;
      err_q <= err_d;
    end
  end

  // Entries are never cleared; only a push overwrites one.
  always_ff @(posedge clk) begin
    if (push_en && !rst) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  assign pc          = pc_q;
  assign o           = o_q;
  assign stack_full  = full;
  assign stack_empty = empty;
  assign stack_err   = err_q;

endmodule
